ram_ws: RTL and testbench

Parametrised data-side RAM with a request/ready handshake, configurable wait states, byte-lane write strobes and out-of-range error reporting. It replaces the zero-latency, single-width data RAM on the core's load/store port. The wait-state count models slower memories without any change to the core side of the interface. It sits between the core's data port and the word-addressed storage array inside the SoC top.

---
 rtl/ram_ws.sv | 82 ++++++++
 tb/tb_ram_ws.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ram_ws.sv
// ram_ws: data RAM with req/ready handshake, wait states, byte strobes and range error
module ram_ws #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                ready,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);
  localparam int NB = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAITING = 2'd1, RESP = 2'd2;
  logic [1:0] state, state_n;
  logic [3:0] cnt;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0] wstrb_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, commit, direct, c_we, c_oor;
  logic [ADDR_W-1:0] c_addr, c_idx;
  logic [DATA_W-1:0] c_wdata;
  logic [NB-1:0] c_wstrb;
  logic [AW-1:0] c_a;
  assign ready = state != WAITING;
  assign done = state == RESP;
  assign acc = req && ready;
  // next state; with no wait states an accepted request commits on its own edge
  always_comb begin
    state_n = acc ? (WAIT == 0 ? RESP : WAITING) : state == WAITING ? (cnt == 4'd1 ? RESP : WAITING) : IDLE;
    commit = state_n == RESP;
    direct = acc && WAIT == 0;
    c_we = direct ? we : we_q;
    c_addr = direct ? addr : addr_q;
    c_wdata = direct ? wdata : wdata_q;
    c_wstrb = direct ? wstrb : wstrb_q;
    c_idx = c_addr >> OFF;
    c_oor = c_idx >= ADDR_W'(DEPTH);
    c_a = c_idx[AW-1:0];
  end
  // control state, latched request and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= acc ? 4'(WAIT) : state == WAITING ? cnt - 4'd1 : 4'd0;
      if (acc) begin
        we_q <= we;
        addr_q <= addr;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      rdata <= commit && !c_we ? (c_oor ? '0 : mem[c_a]) : rdata;
      err <= commit && c_oor;
    end
  end
  // storage array, unreset; only strobed lanes of in-range words are written
  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && !c_oor)
      for (int i = 0; i < NB; i++)
        if (c_wstrb[i]) mem[c_a][8*i +: 8] <= c_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ram_ws.sv
// tb_ram_ws: directed checks of ram_ws with WAIT=2 and WAIT=0 instances
module tb_ram_ws;
  logic clk = 1'b0, rst = 1'b1;
  logic req_a = 0, we_a = 0, ready_a, done_a, err_a;
  logic [31:0] addr_a = 0, wdata_a = 0, rdata_a;
  logic [3:0] wstrb_a = 0;
  logic req_b = 0, we_b = 0, ready_b, done_b, err_b;
  logic [31:0] addr_b = 0, wdata_b = 0, rdata_b;
  logic [3:0] wstrb_b = 0;
  int checks = 0, errors = 0;
  logic [31:0] rd;
  logic e;
  logic [31:0] bd [3] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};

  always #5 clk = ~clk;

  ram_ws #(.WAIT(2)) dut_a (.clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .wstrb(wstrb_a), .ready(ready_a), .done(done_a), .rdata(rdata_a), .err(err_a));
  ram_ws #(.WAIT(0)) dut_b (.clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .wstrb(wstrb_b), .ready(ready_b), .done(done_b), .rdata(rdata_b), .err(err_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic a_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r, output logic er);
    @(negedge clk);
    req_a = 1; we_a = w; addr_a = a; wdata_a = d; wstrb_a = s;
    chk("a_ready_idle", ready_a, 1);
    @(negedge clk);
    req_a = 0;
    chk("a_busy1", ready_a, 0);
    chk("a_nodone1", {done_a, err_a}, 0);
    @(negedge clk);
    chk("a_busy2", ready_a, 0);
    chk("a_nodone2", {done_a, err_a}, 0);
    @(negedge clk);
    chk("a_done", done_a, 1);
    chk("a_ready_resp", ready_a, 1);
    r = rdata_a;
    er = err_a;
  endtask

  initial begin
    #2;
    chk("rst_ready", ready_a, 1);
    chk("rst_done", done_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk);
    rst = 0;
    a_acc(1, 32'h10, 32'h11111111, 4'hF, rd, e);
    a_acc(0, 32'h10, 0, 4'h0, rd, e);
    chk("pre_rst_rd", rd, 32'h11111111);
    @(negedge clk);
    req_a = 1; we_a = 1; addr_a = 32'h10; wdata_a = 32'hDEADBEEF; wstrb_a = 4'hF;
    @(negedge clk);
    req_a = 0;
    chk("mid_waiting", ready_a, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_ready", ready_a, 1);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_rdata", rdata_a, 0);
    @(negedge clk);
    rst = 0;
    a_acc(0, 32'h10, 0, 4'h0, rd, e);
    chk("rst_discard", rd, 32'h11111111);
    a_acc(1, 32'h40, 32'h11223344, 4'hF, rd, e);
    chk("wr_err", e, 0);
    a_acc(0, 32'h40, 0, 4'h0, rd, e);
    chk("rd_40", rd, 32'h11223344);
    chk("rd_40_err", e, 0);
    a_acc(1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, e);
    chk("wr_keeps_rdata", rd, 32'h11223344);
    a_acc(0, 32'h40, 32'hFFFFFFFF, 4'h0, rd, e);
    chk("strobe_merge", rd, 32'h11BB33DD);
    a_acc(0, 32'h40, 0, 4'hF, rd, e);
    chk("rd_strb_ignored", rd, 32'h11BB33DD);
    a_acc(1, 32'h0, 32'h01020304, 4'hF, rd, e);
    a_acc(1, 32'h1000, 32'h55555555, 4'hF, rd, e);
    chk("oor_wr_err", e, 1);
    a_acc(0, 32'h0, 0, 4'h0, rd, e);
    chk("oor_no_alias", rd, 32'h01020304);
    a_acc(0, 32'h1000, 0, 4'h0, rd, e);
    chk("oor_rd_data", rd, 0);
    chk("oor_rd_err", e, 1);
    @(negedge clk);
    chk("err_cleared", {done_a, err_a}, 0);
    a_acc(1, 32'hFFC, 32'h0BADCAFE, 4'hF, rd, e);
    chk("last_wr_err", e, 0);
    a_acc(0, 32'hFFC, 0, 4'h0, rd, e);
    chk("last_rd", rd, 32'h0BADCAFE);
    chk("last_rd_err", e, 0);
    a_acc(1, 32'h41, 32'hCAFEF00D, 4'hF, rd, e);
    a_acc(0, 32'h43, 0, 4'h0, rd, e);
    chk("misaligned", rd, 32'hCAFEF00D);
    chk("misaligned_err", e, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b_done", done_b, 1);
        if (i > 3) chk("b_rdata", rdata_b, bd[i-4]);
      end
      req_b = 1; we_b = i < 3; addr_b = 32'((i % 3) * 4);
      wdata_b = bd[i % 3]; wstrb_b = 4'hF;
    end
    @(negedge clk);
    req_b = 0;
    chk("b_done_last", done_b, 1);
    chk("b_rdata_last", rdata_b, bd[2]);
    chk("b_err", err_b, 0);
    @(negedge clk);
    chk("b_idle", done_b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
